// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

    localparam int SEQ_WIDTH = 16;
    localparam int SEQ_TAG_W = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_ROR = 4'd3;

    // Bit positions inside the 3-bit {overflow, zero, carry} flag field.
    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_V = 2;

    // One buffered response. Field widths track the default WIDTH/TAG_W.
    typedef struct packed {
        logic [SEQ_TAG_W-1:0] tag;
        logic [SEQ_WIDTH-1:0] result;
        logic [2:0]           flags;
        logic                 illegal;
    } rsp_entry_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, response and ALU-side signals of the sequencer.
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// while valid is high and ready is low the sender holds valid and payload stable.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_opcode;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [4:0]       cmd_shift;
    logic [TAG_W-1:0] cmd_tag;

    logic [3:0]       alu_opcode;
    logic [WIDTH-1:0] alu_input1;
    logic [WIDTH-1:0] alu_input2;
    logic [4:0]       alu_shift;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [TAG_W-1:0] rsp_tag;
    logic [WIDTH-1:0] rsp_result;
    logic [2:0]       rsp_flags;
    logic             rsp_illegal;

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag,
        input  alu_result, alu_carry, rsp_ready,
        output cmd_ready, alu_opcode, alu_input1, alu_input2, alu_shift,
        output rsp_valid, rsp_tag, rsp_result, rsp_flags, rsp_illegal
    );

    // Command issuer / response consumer / ALU side.
    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag,
        output alu_result, alu_carry, rsp_ready,
        input  cmd_ready, alu_opcode, alu_input1, alu_input2, alu_shift,
        input  rsp_valid, rsp_tag, rsp_result, rsp_flags, rsp_illegal
    );
endinterface

// File: rtl/alu_rsp_fifo.sv
// First-word-fall-through FIFO holding sequencer responses.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module alu_rsp_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 24,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_rd;

    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_rd   = rd_en && !empty;

    // Next-state: write at tail, pop at head; a simultaneous write and pop
    // leaves the count unchanged, even when the FIFO starts out full.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_en, do_rd})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointers and occupancy are cleared by reset; storage needs no reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage update.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues commands to a fixed-latency pipelined ALU, tracks them through
// the ALU pipeline, and returns in-order tagged responses with locally
// derived flags.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH     = SEQ_WIDTH,
    parameter int TAG_W     = SEQ_TAG_W,
    parameter int ALU_LAT   = 2,
    parameter int RSP_DEPTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    alu_cmd_sequencer_if.slave bus
);
    localparam int NSTG  = ALU_LAT + 1;
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W:0]   DEPTH_CMP = RSP_DEPTH;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t           stg_q [NSTG];
    stage_t           stg_d [NSTG];
    stage_t           last_stg;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [4:0]       alu_sh_q, alu_sh_d;

    logic             accept;
    logic             cmd_ready;
    logic             wr_en;
    rsp_entry_t       wr_entry;
    rsp_entry_t       head;
    logic [$bits(rsp_entry_t)-1:0] rd_data;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             rsp_valid;
    logic             pop;

    // Credits come from registered counts only, so cmd_ready never depends
    // combinationally on cmd_valid or rsp_ready.
    assign cmd_ready     = ({1'b0, inflight_q} + {1'b0, fifo_count}) < DEPTH_CMP;
    assign bus.cmd_ready = cmd_ready;
    assign accept        = bus.cmd_valid && cmd_ready;

    assign last_stg = stg_q[NSTG-1];
    assign wr_en    = last_stg.vld;

    // Pipeline shift: stage 0 loads on accept (bubble otherwise); ALU operand
    // registers update only on accept; inflight counts accept-to-FIFO-write.
    always_comb begin
        stg_d[0] = '0;
        if (accept) begin
            stg_d[0].vld = 1'b1;
            stg_d[0].tag = bus.cmd_tag;
            stg_d[0].op  = bus.cmd_opcode;
            stg_d[0].a   = bus.cmd_a;
            stg_d[0].b   = bus.cmd_b;
        end
        for (int i = 1; i < NSTG; i++) begin
            stg_d[i] = stg_q[i-1];
        end

        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_sh_d = alu_sh_q;
        if (accept) begin
            alu_op_d = bus.cmd_opcode;
            alu_a_d  = bus.cmd_a;
            alu_b_d  = bus.cmd_b;
            alu_sh_d = bus.cmd_shift;
        end

        case ({accept, wr_en})
            2'b10:   inflight_d = inflight_q + CNT_ONE;
            2'b01:   inflight_d = inflight_q - CNT_ONE;
            default: inflight_d = inflight_q;
        endcase
    end

    // Build the response from the ALU result and the command's own operands;
    // the ALU's overflow/zero outputs are deliberately not trusted.
    always_comb begin
        wr_entry     = '0;
        wr_entry.tag = last_stg.tag;
        if (last_stg.op > OP_ROR) begin
            wr_entry.illegal = 1'b1;
        end else begin
            wr_entry.result        = bus.alu_result;
            wr_entry.flags[FLG_Z]  = (bus.alu_result == '0);
            case (last_stg.op)
                OP_ADD: begin
                    wr_entry.flags[FLG_C] = bus.alu_carry;
                    wr_entry.flags[FLG_V] = (last_stg.a[WIDTH-1] == last_stg.b[WIDTH-1]) &&
                                            (bus.alu_result[WIDTH-1] != last_stg.a[WIDTH-1]);
                end
                OP_SUB: begin
                    wr_entry.flags[FLG_C] = bus.alu_carry;
                    wr_entry.flags[FLG_V] = (last_stg.a[WIDTH-1] != last_stg.b[WIDTH-1]) &&
                                            (bus.alu_result[WIDTH-1] != last_stg.a[WIDTH-1]);
                end
                default: begin
                    wr_entry.flags[FLG_C] = 1'b0;
                    wr_entry.flags[FLG_V] = 1'b0;
                end
            endcase
        end
    end

    // Registered state; reset discards every in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSTG; i++) begin
                stg_q[i] <= '0;
            end
            inflight_q <= '0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sh_q   <= '0;
        end else begin
            stg_q      <= stg_d;
            inflight_q <= inflight_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sh_q   <= alu_sh_d;
        end
    end

    assign bus.alu_opcode = alu_op_q;
    assign bus.alu_input1 = alu_a_q;
    assign bus.alu_input2 = alu_b_q;
    assign bus.alu_shift  = alu_sh_q;

    assign pop = rsp_valid && bus.rsp_ready;

    alu_rsp_fifo #(
        .DEPTH  (RSP_DEPTH),
        .DATA_W ($bits(rsp_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Response fields read zero whenever no response is presented.
    assign head            = rd_data;
    assign rsp_valid       = !fifo_empty;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_tag     = rsp_valid ? head.tag     : '0;
    assign bus.rsp_result  = rsp_valid ? head.result  : '0;
    assign bus.rsp_flags   = rsp_valid ? head.flags   : '0;
    assign bus.rsp_illegal = rsp_valid ? head.illegal : 1'b0;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural 2-cycle ALU and a
// reference model of the expected responses.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [23:0] exp_q [$];

    alu_cmd_sequencer_if #(.WIDTH(16), .TAG_W(4)) bus ();

    alu_cmd_sequencer #(
        .WIDTH(16), .TAG_W(4), .ALU_LAT(2), .RSP_DEPTH(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // ALU: operands registered one edge, result registered the next.
    function automatic logic [16:0] alu_eval(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [4:0] sh);
        logic [31:0] p;
        case (op)
            4'd0: return {1'b0, a} + {1'b0, b};
            4'd1: return {(a < b), a - b};
            4'd2: begin p = a * b; return {|p[31:16], p[15:0]}; end
            4'd3: begin p = {a, a} >> sh[3:0]; return {1'b1, p[15:0]}; end
            default: return {1'b1, a ^ b ^ 16'h5A5A};
        endcase
    endfunction

    logic [3:0]  alu_op_r;
    logic [15:0] alu_a_r, alu_b_r;
    logic [4:0]  alu_sh_r;
    always @(posedge clk) begin
        alu_op_r <= bus.alu_opcode;
        alu_a_r  <= bus.alu_input1;
        alu_b_r  <= bus.alu_input2;
        alu_sh_r <= bus.alu_shift;
        {bus.alu_carry, bus.alu_result} <= alu_eval(alu_op_r, alu_a_r, alu_b_r, alu_sh_r);
    end

    // Expected response {tag, result, flags{V,Z,C}, illegal} from signed/unsigned arithmetic.
    function automatic logic [23:0] ref_rsp(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [4:0] sh,
                                            input logic [3:0] tag);
        int unsigned ua, ub, full, s;
        int sa, sb, sr;
        logic [15:0] res;
        logic c, v;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        c = 1'b0; v = 1'b0; res = '0;
        case (op)
            4'd0: begin
                full = ua + ub; res = full[15:0]; c = (full > 32'hFFFF);
                sr = sa + sb; v = (sr > 32767) || (sr < -32768);
            end
            4'd1: begin
                full = ua - ub; res = full[15:0]; c = (ua < ub);
                sr = sa - sb; v = (sr > 32767) || (sr < -32768);
            end
            4'd2: begin full = ua * ub; res = full[15:0]; end
            4'd3: begin
                s = sh % 16;
                full = (ua >> s) | (ua << (16 - s));
                res = full[15:0];
            end
            default: return {tag, 16'h0000, 3'b000, 1'b1};
        endcase
        return {tag, res, v, (res == 16'h0000), c, 1'b0};
    endfunction

    // Scoreboard: record accepts, compare pops, and check rsp hold under backpressure.
    logic [23:0] prev_rsp, cur_rsp;
    logic        prev_hold;
    always @(negedge clk) begin
        cur_rsp = {bus.rsp_tag, bus.rsp_result, bus.rsp_flags, bus.rsp_illegal};
        if (!rst_n) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("rsp_hold_valid", bus.rsp_valid, 1);
                chk("rsp_hold_data", cur_rsp, prev_rsp);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", exp_q.size(), 1);
                else chk("rsp_data", cur_rsp, exp_q.pop_front());
            end
            if (bus.cmd_valid && bus.cmd_ready)
                exp_q.push_back(ref_rsp(bus.cmd_opcode, bus.cmd_a, bus.cmd_b, bus.cmd_shift, bus.cmd_tag));
            prev_hold = bus.rsp_valid && !bus.rsp_ready;
            prev_rsp  = cur_rsp;
        end
    end

    task automatic set_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [4:0] sh, input logic [3:0] tag);
        bus.cmd_opcode = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_shift = sh; bus.cmd_tag = tag;
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 4))
            0: return 16'h0000;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic rand_cmd(input logic [3:0] tag);
        logic [3:0] op;
        if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(4, 15));
        else op = 4'($urandom_range(0, 3));
        set_cmd(op, pick_operand(), pick_operand(), 5'($urandom_range(0, 31)), tag);
    endtask

    // Issue one command, then measure cycles until rsp_valid; returns at the
    // negedge where the response is first visible.
    task automatic send_one(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [4:0] sh, input logic [3:0] tag, output int lat);
        logic acc, got;
        int n;
        @(posedge clk); #1;
        set_cmd(op, a, b, sh, tag);
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        acc = 1'b0; n = 0;
        while (!acc && n < 20) begin
            @(negedge clk); acc = bus.cmd_ready;
            @(posedge clk); #1; n++;
        end
        bus.cmd_valid = 1'b0;
        chk("send_accept", acc, 1);
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk); lat++;
            @(negedge clk); got = bus.rsp_valid;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        bus.rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.rsp_valid) && n < 60) begin
            @(negedge clk); n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({pfx, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({pfx, "_rsp_fields"}, {bus.rsp_tag, bus.rsp_result, bus.rsp_flags, bus.rsp_illegal}, 0);
        chk({pfx, "_alu_op"}, bus.alu_opcode, 0);
        chk({pfx, "_alu_ops"}, {bus.alu_input1, bus.alu_input2}, 0);
        chk({pfx, "_alu_sh"}, bus.alu_shift, 0);
    endtask

    initial begin
        int lat, n_acc, quiet;
        logic [3:0] k;
        logic fire;
        checks = 0; errors = 0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
        set_cmd(4'd0, 16'h0, 16'h0, 5'd0, 4'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed single commands from the test plan.
        send_one(OP_ADD, 16'h7FFF, 16'h0001, 5'd0, 4'd1, lat);
        chk("add_latency", lat, 3);
        chk("add_result", bus.rsp_result, 16'h8000);
        chk("add_flags", bus.rsp_flags, 3'b100);
        chk("add_tag", bus.rsp_tag, 4'd1);
        chk("add_alu_in1", bus.alu_input1, 16'h7FFF);
        chk("add_alu_in2", bus.alu_input2, 16'h0001);

        send_one(OP_SUB, 16'h0000, 16'h0001, 5'd0, 4'd2, lat);
        chk("sub_latency", lat, 3);
        chk("sub_result", bus.rsp_result, 16'hFFFF);
        chk("sub_flags", bus.rsp_flags, 3'b001);

        send_one(OP_MUL, 16'h0100, 16'h0100, 5'd0, 4'd3, lat);
        chk("mul_result", bus.rsp_result, 16'h0000);
        chk("mul_flags", bus.rsp_flags, 3'b010);

        send_one(OP_ROR, 16'h0001, 16'h0000, 5'd1, 4'd4, lat);
        chk("ror_result", bus.rsp_result, 16'h8000);
        chk("ror_flags", bus.rsp_flags, 3'b000);
        chk("ror_alu_shift", bus.alu_shift, 5'd1);

        send_one(4'd5, 16'h1234, 16'h00FF, 5'd0, 4'd5, lat);
        chk("ill_flag", bus.rsp_illegal, 1);
        chk("ill_result", bus.rsp_result, 16'h0000);
        chk("ill_flags", bus.rsp_flags, 3'b000);

        // Illegal opcode between legal neighbours, back to back.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        set_cmd(OP_ADD, 16'h4000, 16'h4000, 5'd0, 4'd6);
        @(negedge clk); chk("burst_ready0", bus.cmd_ready, 1);
        @(posedge clk); #1;
        set_cmd(4'd5, 16'h1234, 16'h0001, 5'd0, 4'd7);
        @(negedge clk); chk("burst_ready1", bus.cmd_ready, 1);
        @(posedge clk); #1;
        set_cmd(OP_SUB, 16'h8000, 16'h0001, 5'd0, 4'd8);
        @(negedge clk); chk("burst_ready2", bus.cmd_ready, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        wait_drain();

        // Backpressure: six offered commands with rsp_ready low.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        k = 4'd0; n_acc = 0;
        rand_cmd(k);
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); fire = bus.cmd_ready;
            @(posedge clk); #1;
            if (fire) begin n_acc++; k = k + 4'd1; rand_cmd(k); end
        end
        bus.cmd_valid = 1'b0;
        chk("bp_accepted", n_acc, 4);
        chk("bp_ready_low", bus.cmd_ready, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_ready_still_low", bus.cmd_ready, 0);
        chk("bp_head_valid", bus.rsp_valid, 1);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_pop_valid", bus.rsp_valid, 1);
            chk("bp_pop_tag", bus.rsp_tag, i);
            @(posedge clk); #1;
            if (i == 0) chk("bp_ready_back", bus.cmd_ready, 1);
        end
        @(negedge clk);
        chk("bp_empty", bus.rsp_valid, 0);

        // Random traffic with random backpressure.
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk); fire = bus.cmd_valid && bus.cmd_ready;
            @(posedge clk); #1;
            if (!bus.cmd_valid || fire) begin
                bus.cmd_valid = ($urandom_range(0, 3) != 0);
                rand_cmd(4'(cyc));
            end
            bus.rsp_ready = ($urandom_range(0, 2) != 0);
        end
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 20 && bus.cmd_valid; n++) begin
            @(negedge clk); fire = bus.cmd_ready;
            @(posedge clk); #1;
            if (fire) bus.cmd_valid = 1'b0;
        end
        chk("rand_last_accepted", bus.cmd_valid, 0);
        wait_drain();

        // Reset one cycle after two accepted commands.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        set_cmd(OP_ADD, 16'h0011, 16'h0022, 5'd0, 4'd9);
        @(posedge clk); #1;
        set_cmd(OP_SUB, 16'h0033, 16'h0001, 5'd0, 4'd10);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) quiet++;
        end
        chk("post_reset_no_rsp", quiet, 0);
        send_one(OP_ADD, 16'h0002, 16'h0003, 5'd0, 4'd11, lat);
        chk("post_reset_latency", lat, 3);
        chk("post_reset_result", bus.rsp_result, 16'h0005);
        chk("post_reset_tag", bus.rsp_tag, 4'd11);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

- Initiator-side companion to the pipelined 16-bit ALU.
- Accepts operation commands over a valid/ready handshake and drives the ALU operand/opcode ports.
- Tracks the ALU's fixed pipeline latency and captures each result with locally corrected flags into a response buffer.
- Returns responses in order with the command's tag over a second valid/ready handshake, so upstream logic never needs to know ALU latency.

## Interface
Parameters:
- WIDTH, 16, operand/result width
- TAG_W, 4, command tag width
- ALU_LAT, 2, cycles from ALU port change to registered ALU result
- RSP_DEPTH, 4, response buffer entries (power of two)

Ports:
- clk  in  1  single clock; rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_opcode  in  4  0=ADD 1=SUB 2=MUL 3=ROR; others illegal
- cmd_a, cmd_b  in  WIDTH  operands
- cmd_shift  in  5  rotate amount (ROR only)
- cmd_tag  in  TAG_W  returned unchanged
- alu_opcode  out  4  to ALU opcode
- alu_input1, alu_input2  out  WIDTH  to ALU operands
- alu_shift  out  5  to ALU shiftValue
- alu_result  in  WIDTH  ALU result
- alu_carry  in  1  ALU carryFlag
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_tag  out  TAG_W  tag of the command
- rsp_result  out  WIDTH  result
- rsp_flags  out  3  {overflow, zero, carry}
- rsp_illegal  out  1  opcode was >3

## Operation
- alu_* outputs are registered.
  - Updated only on an accepted command; otherwise hold their last value.
  - Reset value 0.
- Credit rule: cmd_ready = (inflight + fifo_count) < RSP_DEPTH.
  - Computed from registered counts only; no combinational path from rsp_ready or cmd_valid.
  - inflight counts commands from acceptance until their FIFO write.
- In-flight pipeline: a shift register of ALU_LAT+1 stages.
  - Each stage holds {valid, tag, opcode, a, b}.
  - Stage 0 loads on accept; otherwise a bubble.
- On the last stage valid, write the FIFO with the following fields:
  - result = alu_result.
  - carry = alu_carry for ADD/SUB, else 0.
  - zero = (alu_result == 0), computed locally for all opcodes.
  - overflow, computed locally from the stored a, b and alu_result:
    - ADD: a[msb]==b[msb] && res[msb]!=a[msb].
    - SUB: a[msb]!=b[msb] && res[msb]!=a[msb].
    - MUL/ROR: 0.
  - The ALU's own overflow and zero outputs are not used.
- Illegal opcode:
  - Accepted and issued normally.
  - Response has rsp_illegal=1, result forced 0, flags forced 0.
- The response FIFO is first-word-fall-through. rsp_* shows the head entry when rsp_valid=1.
- Simultaneous FIFO write and pop in one cycle is legal, including when the FIFO is full before the pop.
- The credit rule guarantees a write never finds the FIFO full.

## Timing
- Accept at edge E0:
  - alu_* valid after E0.
  - ALU registers at E1 and produces its result after E2.
  - Sequencer writes the FIFO at E3.
  - rsp_valid rises after E3 if the FIFO was empty.
- Accept-to-rsp_valid latency = ALU_LAT+1 = 3 cycles.
- Throughput: one command per cycle while credits are available.
- Responses are strictly in acceptance order.
- rsp_* are stable while rsp_valid=1 and rsp_ready=0.
- Reset values:
  - cmd_ready=1, rsp_valid=0.
  - rsp_tag, rsp_result, rsp_flags and rsp_illegal = 0.
  - alu_* = 0.
- Reset asserted mid-operation:
  - All in-flight commands and buffered responses are discarded.
  - No response appears after reset release for commands accepted before reset.

## Structure
- Package alu_seq_pkg holds:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_ROR=3.
  - flag bit indices FLG_C=0, FLG_Z=1, FLG_V=2.
  - the response entry packed struct {tag, result, flags, illegal}.
- Sub-module alu_rsp_fifo: synchronous FWFT FIFO, parameterised depth/width, with count output used by the credit rule.

## Test plan
- ADD a=0x7FFF b=0x0001 tag=1 -> 3 cycles later: rsp_result=0x8000, flags {V=1,Z=0,C=0}, tag=1.
- SUB a=0x0000 b=0x0001 -> rsp_result=0xFFFF, C=1, V=0, Z=0.
- MUL a=0x0100 b=0x0100 -> rsp_result=0x0000, Z=1, C=0, V=0. ROR a=0x0001 shift=1 -> 0x8000, flags 0.
- Back-to-back flow with rsp_ready=0, six consecutive commands:
  - Exactly 4 accepted; cmd_ready low from then on.
  - Raise rsp_ready: tags 0..3 return in order; cmd_ready reasserts on the first pop's following cycle.
- Opcode 5 with a=0x1234 -> rsp_illegal=1, rsp_result=0, flags 0; neighbouring legal commands unaffected.
- Reset pulse one cycle after accepting two commands:
  - All outputs return to reset values.
  - No responses emitted afterwards.
  - A new ADD 2+3 returns 5 with latency 3.
